// File: rtl/accum_feeder_if.sv
// Host/accumulator-facing bundle for accum_feeder: start handshake, operands,
// accumulator control strobes and the neuron result.
interface accum_feeder_if #(
  parameter int NI = 8,
  parameter int B  = 8
) ();
  logic            start;
  logic [NI*B-1:0] features;
  logic [NI-1:0]   weights;
  logic            ready;
  logic [B-1:0]    acc_data;
  logic            acc_add_sub;
  logic            acc_put;
  logic            acc_clr;
  logic            acc_out;
  logic            result;
  logic            result_valid;

  modport master (
    output start, features, weights, acc_out,
    input  ready, acc_data, acc_add_sub, acc_put, acc_clr, result, result_valid
  );

  modport slave (
    input  start, features, weights, acc_out,
    output ready, acc_data, acc_add_sub, acc_put, acc_clr, result, result_valid
  );
endinterface

// File: rtl/accum_feeder.sv
// Streams NI features into an external add/sub accumulator under binary weights,
// then captures the accumulator's sign decision as the neuron output.
module accum_feeder #(
  parameter int NI = 8,
  parameter int B  = 8
) (
  input  logic           clk,
  input  logic           rst,
  accum_feeder_if.slave  bus
);

  localparam int IW = (NI > 1) ? $clog2(NI) : 1;
  localparam logic [IW-1:0] LAST = IW'(NI - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          r_state, w_state_nx;
  logic [IW-1:0]   r_idx, w_idx_nx;
  logic [NI*B-1:0] r_features;
  logic [NI-1:0]   r_weights;
  logic            w_accept;

  logic [NI*B-1:0] w_feat_src;
  logic [NI-1:0]   w_wt_src;
  logic [B-1:0]    w_sel_data;
  logic            w_sel_wt;

  logic            w_ready_nx, w_add_sub_nx, w_put_nx, w_clr_nx, w_valid_nx;
  logic [B-1:0]    w_data_nx;

  logic            r_ready, r_acc_add_sub, r_acc_put, r_acc_clr, r_result, r_result_valid;
  logic [B-1:0]    r_acc_data;

  assign w_accept = bus.start && (r_state == S_IDLE);

  // State, index and operand latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_features <= '0;
      r_weights  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      if (w_accept) begin
        r_features <= bus.features;
        r_weights  <= bus.weights;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = S_STREAM;
          w_idx_nx   = '0;
        end
      end
      S_STREAM: begin
        if (r_idx == LAST) begin
          w_state_nx = S_CAPTURE;
          w_idx_nx   = '0;
        end else begin
          w_idx_nx = r_idx + 1'b1;
        end
      end
      S_CAPTURE: w_state_nx = S_DONE;
      S_DONE:    w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the first feature has to
  // come straight from the port on the accept edge, before the latch holds it.
  always_comb begin
    w_feat_src = (r_state == S_IDLE) ? bus.features : r_features;
    w_wt_src   = (r_state == S_IDLE) ? bus.weights  : r_weights;
    w_sel_data = '0;
    w_sel_wt   = 1'b0;
    for (int unsigned i = 0; i < NI; i++) begin
      if (w_idx_nx == IW'(i)) begin
        w_sel_data = w_feat_src[i*B +: B];
        w_sel_wt   = w_wt_src[i];
      end
    end
  end

  always_comb begin
    w_ready_nx   = 1'b0;
    w_data_nx    = '0;
    w_add_sub_nx = 1'b0;
    w_put_nx     = 1'b0;
    w_clr_nx     = 1'b0;
    w_valid_nx   = 1'b0;
    case (w_state_nx)
      S_IDLE:    w_ready_nx = 1'b1;
      S_STREAM: begin
        w_data_nx    = w_sel_data;
        w_add_sub_nx = w_sel_wt;
        w_put_nx     = (w_idx_nx == LAST);
      end
      S_CAPTURE: w_clr_nx   = 1'b1;
      S_DONE:    w_valid_nx = 1'b1;
      default:   w_ready_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready        <= 1'b1;
      r_acc_data     <= '0;
      r_acc_add_sub  <= 1'b0;
      r_acc_put      <= 1'b0;
      r_acc_clr      <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= 1'b0;
    end else begin
      r_ready        <= w_ready_nx;
      r_acc_data     <= w_data_nx;
      r_acc_add_sub  <= w_add_sub_nx;
      r_acc_put      <= w_put_nx;
      r_acc_clr      <= w_clr_nx;
      r_result_valid <= w_valid_nx;
      if (r_state == S_CAPTURE)
        r_result <= bus.acc_out;
    end
  end

  assign bus.ready        = r_ready;
  assign bus.acc_data     = r_acc_data;
  assign bus.acc_add_sub  = r_acc_add_sub;
  assign bus.acc_put      = r_acc_put;
  assign bus.acc_clr      = r_acc_clr;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_accum_feeder.sv
// Bench for accum_feeder: NI=4 and NI=1 instances, each with a behavioural
// accumulator, a result scoreboard and cycle-exact stream checks.
module tb_accum_feeder;

  logic clk;
  logic rst;

  accum_feeder_if #(.NI(4), .B(8)) if4 ();
  accum_feeder_if #(.NI(1), .B(8)) if1 ();

  accum_feeder #(.NI(4), .B(8)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  accum_feeder #(.NI(1), .B(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit exp4[$];
  bit exp1[$];
  int acc_times[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_sign(input logic [31:0] f, input logic [3:0] w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) begin
      if (w[i]) s += int'(f[i*8 +: 8]);
      else      s -= int'(f[i*8 +: 8]);
    end
    return (s >= 0);
  endfunction

  // Behavioural accumulators: sum cleared asynchronously, sign latched on put
  int sum4, sum1;
  logic dec4, dec1;
  always @(posedge clk or posedge if4.acc_clr or posedge rst) begin
    if (rst) begin
      sum4 <= 0; dec4 <= 1'b0;
    end else if (if4.acc_clr) begin
      sum4 <= 0;
    end else begin
      sum4 <= sum4 + (if4.acc_add_sub ? int'(if4.acc_data) : -int'(if4.acc_data));
      if (if4.acc_put)
        dec4 <= ((sum4 + (if4.acc_add_sub ? int'(if4.acc_data) : -int'(if4.acc_data))) >= 0);
    end
  end
  always @(posedge clk or posedge if1.acc_clr or posedge rst) begin
    if (rst) begin
      sum1 <= 0; dec1 <= 1'b0;
    end else if (if1.acc_clr) begin
      sum1 <= 0;
    end else begin
      sum1 <= sum1 + (if1.acc_add_sub ? int'(if1.acc_data) : -int'(if1.acc_data));
      if (if1.acc_put)
        dec1 <= ((sum1 + (if1.acc_add_sub ? int'(if1.acc_data) : -int'(if1.acc_data))) >= 0);
    end
  end
  assign if4.acc_out = dec4;
  assign if1.acc_out = dec1;

  // Scoreboard: push on the edge that will accept, pop on result_valid
  always @(negedge clk) begin
    if (!rst && if4.start && if4.ready) begin
      exp4.push_back(model_sign(if4.features, if4.weights, 4));
      acc_times.push_back(cyc);
    end
    if (!rst && if1.start && if1.ready)
      exp1.push_back(model_sign(32'(if1.features), 4'(if1.weights), 1));
    if (if4.result_valid) begin
      if (exp4.size() == 0) check_eq("sb4_unexpected_valid", 32'(if4.result_valid), 32'd0);
      else                  check_eq("sb4_result", 32'(if4.result), 32'(exp4.pop_front()));
    end
    if (if1.result_valid) begin
      if (exp1.size() == 0) check_eq("sb1_unexpected_valid", 32'(if1.result_valid), 32'd0);
      else                  check_eq("sb1_result", 32'(if1.result), 32'(exp1.pop_front()));
    end
  end

  task automatic wait_ready4();
    int g = 0;
    while (!if4.ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("ready4_wait", 32'(if4.ready), 32'd1);
  endtask

  task automatic run_eval4(input logic [31:0] f, input logic [3:0] w);
    bit r;
    r = model_sign(f, w, 4);
    wait_ready4();
    if4.features = f;
    if4.weights  = w;
    if4.start    = 1'b1;
    @(posedge clk); #1;
    if4.start    = 1'b0;
    if4.features = $urandom;
    if4.weights  = 4'($urandom);
    for (int c = 1; c <= 4; c++) begin
      check_eq("s4_data",   32'(if4.acc_data),    32'(f[(c-1)*8 +: 8]));
      check_eq("s4_addsub", 32'(if4.acc_add_sub), 32'(w[c-1]));
      check_eq("s4_put",    32'(if4.acc_put),     32'(c == 4));
      check_eq("s4_busy",   32'(if4.ready),       32'd0);
      if (c == 2) if4.start = 1'b1;
      if (c == 3) if4.start = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("c4_clr",  32'(if4.acc_clr),  32'd1);
    check_eq("c4_put",  32'(if4.acc_put),  32'd0);
    check_eq("c4_data", 32'(if4.acc_data), 32'd0);
    @(posedge clk); #1;
    check_eq("d4_valid",  32'(if4.result_valid), 32'd1);
    check_eq("d4_result", 32'(if4.result),       32'(r));
    check_eq("d4_clr",    32'(if4.acc_clr),      32'd0);
    @(posedge clk); #1;
    check_eq("i4_ready", 32'(if4.ready),        32'd1);
    check_eq("i4_valid", 32'(if4.result_valid), 32'd0);
    check_eq("i4_hold",  32'(if4.result),       32'(r));
  endtask

  task automatic run_eval1(input logic [7:0] f, input logic w);
    int g = 0;
    while (!if1.ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("ready1_wait", 32'(if1.ready), 32'd1);
    if1.features = f;
    if1.weights  = w;
    if1.start    = 1'b1;
    @(posedge clk); #1;
    if1.start    = 1'b0;
    if1.features = 8'($urandom);
    check_eq("s1_put",    32'(if1.acc_put),     32'd1);
    check_eq("s1_data",   32'(if1.acc_data),    32'(f));
    check_eq("s1_addsub", 32'(if1.acc_add_sub), 32'(w));
    @(posedge clk); #1;
    check_eq("c1_clr", 32'(if1.acc_clr), 32'd1);
    check_eq("c1_put", 32'(if1.acc_put), 32'd0);
    @(posedge clk); #1;
    check_eq("d1_valid",  32'(if1.result_valid), 32'd1);
    check_eq("d1_result", 32'(if1.result),       32'(w | (f == 8'd0)));
    @(posedge clk); #1;
    check_eq("i1_ready", 32'(if1.ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    if4.start = 1'b0; if4.features = '0; if4.weights = '0;
    if1.start = 1'b0; if1.features = '0; if1.weights = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data",   32'(if4.acc_data),     32'd0);
    check_eq("rst_addsub", 32'(if4.acc_add_sub),  32'd0);
    check_eq("rst_put",    32'(if4.acc_put),      32'd0);
    check_eq("rst_clr",    32'(if4.acc_clr),      32'd0);
    check_eq("rst_result", 32'(if4.result),       32'd0);
    check_eq("rst_valid",  32'(if4.result_valid), 32'd0);
    check_eq("rst_valid1", 32'(if1.result_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready4", 32'(if4.ready), 32'd1);
    check_eq("post_rst_ready1", 32'(if1.ready), 32'd1);

    // Directed sums: +40, -40, exactly zero
    run_eval4({8'd10, 8'd10, 8'd10, 8'd10}, 4'b1111);
    run_eval4({8'd10, 8'd10, 8'd10, 8'd10}, 4'b0000);
    run_eval4({8'd10, 8'd10, 8'd10, 8'd10}, 4'b0011);
    run_eval4({8'd255, 8'd0, 8'd1, 8'd254}, 4'b0101);
    for (int k = 0; k < 6; k++)
      run_eval4($urandom, 4'($urandom));

    // start held high: accepts exactly NI+3 cycles apart
    acc_times.delete();
    wait_ready4();
    if4.features = {8'd3, 8'd9, 8'd27, 8'd81};
    if4.weights  = 4'b1010;
    if4.start    = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    if4.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("b2b_count", 32'(acc_times.size()), 32'd3);
    if (acc_times.size() == 3) begin
      check_eq("b2b_gap1", 32'(acc_times[1] - acc_times[0]), 32'd7);
      check_eq("b2b_gap2", 32'(acc_times[2] - acc_times[1]), 32'd7);
    end

    // Reset during STREAM abandons the evaluation
    wait_ready4();
    if4.features = {8'd10, 8'd10, 8'd10, 8'd10};
    if4.weights  = 4'b0000;
    if4.start    = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp4.delete();
    check_eq("midrst_data",   32'(if4.acc_data),     32'd0);
    check_eq("midrst_addsub", 32'(if4.acc_add_sub),  32'd0);
    check_eq("midrst_put",    32'(if4.acc_put),      32'd0);
    check_eq("midrst_clr",    32'(if4.acc_clr),      32'd0);
    check_eq("midrst_valid",  32'(if4.result_valid), 32'd0);
    check_eq("midrst_result", 32'(if4.result),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check_eq("midrst_no_valid", 32'(if4.result_valid), 32'd0);
    end
    run_eval4({8'd10, 8'd10, 8'd10, 8'd10}, 4'b1111);

    // NI=1 instance
    run_eval1(8'hFF, 1'b0);
    run_eval1(8'h05, 1'b1);
    run_eval1(8'h00, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check_eq("sb4_drained", 32'(exp4.size()), 32'd0);
    check_eq("sb1_drained", 32'(exp1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
